// File: rtl/pe_accum_tree.sv
// pe_accum_tree
//   Pipelined adder tree plus accumulator for the PE datapath. Each accepted beat
//   carries NUM_IN signed shifted partial products. The block sums them in two
//   pipeline stages and then adds the beat total into an ACC_W-bit running sum.
//   in_first seeds the sum with in_bias. in_last emits the result.
//
//   Optional build macro: PE_ACC_SAT_EN
//     defined   -> the accumulate step saturates and ovf is a sticky clamp flag
//     undefined -> the accumulate step wraps and ovf is tied to 0
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input beat handshake
//   in_data               NUM_IN packed signed lanes of IN_W bits
//   in_first / in_last    accumulation open / close markers
//   in_bias               signed seed, used only with in_first
//   out_valid / out_ready result handshake
//   out_data              signed accumulated result
//   ovf                   sticky overflow flag (saturating build only)
module pe_accum_tree #(
   parameter int unsigned NUM_IN = 16,
   parameter int unsigned IN_W   = 16,
   parameter int unsigned ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_IN*IN_W-1:0]   in_data,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [ACC_W-1:0]         in_bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         out_data,
   output logic                     ovf
);

   localparam int unsigned NG  = NUM_IN / 4;
   localparam int unsigned GW  = IN_W + 2;
   localparam int unsigned AW1 = ACC_W + 1;

   // A held result freezes the whole pipeline, so no stage ever needs a skid buffer.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // ---------------- S1: groups of four lanes ----------------
   logic signed [GW-1:0] grp_c [NG];

   always_comb begin
      for (int unsigned g = 0; g < NG; g++) begin
         grp_c[g] = '0;
         for (int unsigned k = 0; k < 4; k++)
            grp_c[g] = grp_c[g] + GW'($signed(in_data[(g*4+k)*IN_W +: IN_W]));
      end
   end

   logic                    s1_valid, s1_first, s1_last;
   logic signed [ACC_W-1:0] s1_bias;
   logic signed [GW-1:0]    s1_grp [NG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_bias  <= '0;
         s1_grp   <= '{default: '0};
      end else if (!stall) begin
         s1_valid <= in_valid;
         s1_first <= in_first;
         s1_last  <= in_last;
         s1_bias  <= in_bias;
         s1_grp   <= grp_c;
      end
   end

   // ---------------- S2: sum of group sums ----------------
   logic signed [ACC_W-1:0] tree_c;

   always_comb begin
      tree_c = '0;
      for (int unsigned g = 0; g < NG; g++)
         tree_c = tree_c + ACC_W'(s1_grp[g]);
   end

   logic                    s2_valid, s2_first, s2_last;
   logic signed [ACC_W-1:0] s2_bias, s2_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_bias  <= '0;
         s2_sum   <= '0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_bias  <= s1_bias;
         s2_sum   <= tree_c;
      end
   end

   // ---------------- S3: accumulate ----------------
   logic signed [ACC_W-1:0] acc, base, nxt;

`ifdef PE_ACC_SAT_EN
   logic signed [AW1-1:0] wide;
   logic                  clamp;

   // One guard bit is enough: two ACC_W operands cannot overflow ACC_W+1 bits.
   always_comb begin
      base  = s2_first ? s2_bias : acc;
      wide  = AW1'(base) + AW1'(s2_sum);
      clamp = wide[ACC_W] ^ wide[ACC_W-1];
      if (clamp)
         nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         nxt = wide[ACC_W-1:0];
   end

   // Sticky flag. A first beat starts a clean accumulation unless it clamps itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (!stall && s2_valid) begin
         if (clamp)
            ovf <= 1'b1;
         else if (s2_first)
            ovf <= 1'b0;
      end
   end
`else
   always_comb begin
      base = s2_first ? s2_bias : acc;
      nxt  = base + s2_sum;
   end

   assign ovf = 1'b0;
`endif

   // When not stalled, either out_valid is low or the result is being taken this edge.
   // out_valid can therefore simply follow "a last beat lands now".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         out_valid <= s2_valid & s2_last;
         if (s2_valid) begin
            acc <= nxt;
            if (s2_last)
               out_data <= nxt;
         end
      end
   end

endmodule

// File: tb/tb_pe_accum_tree.sv
// tb_pe_accum_tree
//   Self-checking bench for pe_accum_tree with default parameters.
//   A reference model computes each result when a beat is driven and queues it.
//   A monitor pops the queue on every output handshake and compares.
//   Scenario tasks add their own timing, flow-control and flag checks.
//   Builds with or without PE_ACC_SAT_EN.
module tb_pe_accum_tree;

   localparam int NUM_IN = 16;
   localparam int IN_W   = 16;
   localparam int ACC_W  = 24;
   localparam int DW     = NUM_IN * IN_W;

   logic              clk, rst;
   logic              in_valid, in_ready, in_first, in_last;
   logic [DW-1:0]     in_data;
   logic [ACC_W-1:0]  in_bias;
   logic              out_valid, out_ready, ovf;
   logic [ACC_W-1:0]  out_data;

   pe_accum_tree #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last), .in_bias(in_bias),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [ACC_W-1:0] exp_q [$];
   longint           m_acc = 0;
   bit               m_ovf = 0;

   function automatic logic [DW-1:0] fill(input logic [IN_W-1:0] v);
      return {NUM_IN{v}};
   endfunction

   function automatic longint lane_sum(input logic [DW-1:0] d);
      longint s = 0;
      logic signed [IN_W-1:0] l;
      for (int i = 0; i < NUM_IN; i++) begin
         l = d[i*IN_W +: IN_W];
         s += longint'(l);
      end
      return s;
   endfunction

   // Reference accumulate step; pushes the expected result for last beats.
   task automatic model(input logic [DW-1:0] d, input bit f, input bit l,
                        input logic signed [ACC_W-1:0] b);
      longint n;
      bit     c;
      logic signed [ACC_W-1:0] t;
      n = (f ? longint'(b) : m_acc) + lane_sum(d);
      c = 0;
`ifdef PE_ACC_SAT_EN
      if (n > 64'sd8388607) begin n = 64'sd8388607; c = 1; end
      else if (n < -64'sd8388608) begin n = -64'sd8388608; c = 1; end
      m_ovf = f ? c : (m_ovf | c);
`else
      t = n[ACC_W-1:0];
      n = longint'(t);
      m_ovf = 0;
`endif
      m_acc = n;
      if (l) exp_q.push_back(n[ACC_W-1:0]);
   endtask

   // Drive one beat and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic beat(input logic [DW-1:0] d, input bit f, input bit l,
                       input logic signed [ACC_W-1:0] b);
      bit ok = 0;
      model(d, f, l, b);
      in_valid = 1; in_data = d; in_first = f; in_last = l; in_bias = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL beat_accept timeout got in_ready=%0b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 0; in_first = 0; in_last = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending required 0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: every accepted result must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output got %0d required none", $signed(out_data));
         end else begin
            logic [ACC_W-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_err++;
               $display("FAIL result got %0d required %0d", $signed(out_data), $signed(e));
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1; in_valid = 0; in_first = 0; in_last = 0; in_data = '0; in_bias = '0;
      out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state got v=%0b d=%0h ovf=%0b required 0 0 0", out_valid, out_data, ovf);
      end
      rst = 0; #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready got %0b required 1", in_ready);
      end
   endtask

   task automatic test_latency();
      beat(fill(16'd1), 1, 1, 24'sd5);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_edge1 got %0b required 0", out_valid); end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_edge2 got %0b required 0", out_valid); end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 24'd21) begin
         n_err++;
         $display("FAIL lat_edge3 got v=%0b d=%0d required v=1 d=21", out_valid, out_data);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_width got %0b required 0", out_valid); end
      drain();
   endtask

   task automatic test_mixed();
      logic [DW-1:0] d;
      bit seen = 0;
      for (int i = 0; i < NUM_IN; i++) d[i*IN_W +: IN_W] = (i < 8) ? 16'hFFFF : 16'h7FFF;
      beat(d, 1, 1, 24'sd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
      end
      n_cmp++;
      if (!seen || out_data !== 24'd262128) begin
         n_err++;
         $display("FAIL mixed_lanes got seen=%0b d=%0d required 262128", seen, out_data);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int cnt = 0;
      beat(fill(16'd2), 1, 0, -24'sd10);
      beat(fill(16'd2), 0, 0, 24'sd0);
      beat(fill(16'd2), 0, 1, 24'sd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) begin
            cnt++;
            n_cmp++;
            if (out_data !== 24'd86) begin
               n_err++;
               $display("FAIL multibeat_data got %0d required 86", $signed(out_data));
            end
         end
      end
      n_cmp++;
      if (cnt != 1) begin n_err++; $display("FAIL multibeat_width got %0d cycles required 1", cnt); end
      drain();
   endtask

   task automatic test_backpressure();
      bit seen = 0;
      out_ready = 0;
      beat(fill(16'd3), 1, 1, 24'sd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
      end
      n_cmp++;
      if (!seen) begin n_err++; $display("FAIL stall_wait got out_valid=0 required 1"); end
      // Present the next beat while the result is held.
      model(fill(16'd1), 1, 1, 24'sd0);
      in_valid = 1; in_data = fill(16'd1); in_first = 1; in_last = 1; in_bias = '0;
      repeat (5) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 24'd48) begin
            n_err++;
            $display("FAIL stall_hold got rdy=%0b v=%0b d=%0d required 0 1 48", in_ready, out_valid, out_data);
         end
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(posedge clk); #1;
      in_valid = 0; in_first = 0; in_last = 0;
      drain();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup got out_valid=%0b required 0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] d;
      bit seen = 0;
      logic [ACC_W-1:0] exp_d;
      bit exp_ovf;
`ifdef PE_ACC_SAT_EN
      exp_d = 24'h7FFFFF; exp_ovf = 1;
`else
      exp_d = 24'h800000; exp_ovf = 0;
`endif
      d = '0;
      d[IN_W-1:0] = 16'd1;
      beat(d, 1, 1, 24'sh7FFFFF);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
      end
      n_cmp++;
      if (!seen || out_data !== exp_d || ovf !== exp_ovf) begin
         n_err++;
         $display("FAIL overflow got d=%0h ovf=%0b required d=%0h ovf=%0b", out_data, ovf, exp_d, exp_ovf);
      end
      drain();
      n_cmp++;
      if (ovf !== m_ovf) begin n_err++; $display("FAIL ovf_sticky got %0b required %0b", ovf, m_ovf); end
      beat(fill(16'd0), 1, 1, 24'sd0);
      drain();
      n_cmp++;
      if (ovf !== 1'b0 || ovf !== m_ovf) begin
         n_err++;
         $display("FAIL ovf_clear got %0b required 0", ovf);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      beat(fill(16'd2), 1, 0, -24'sd10);
      beat(fill(16'd2), 0, 0, 24'sd0);
      rst = 1; #1;
      exp_q.delete(); m_acc = 0; m_ovf = 0;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         n_err++;
         $display("FAIL midreset got v=%0b d=%0d required 0 0", out_valid, out_data);
      end
      @(posedge clk); #1;
      rst = 0;
      // No first marker: result shows the accumulator restarted from zero.
      beat(fill(16'd1), 0, 1, 24'sd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
      end
      n_cmp++;
      if (!seen || out_data !== 24'd16) begin
         n_err++;
         $display("FAIL midreset_acc got seen=%0b d=%0d required 16", seen, out_data);
      end
      drain();
      beat(fill(16'd2), 1, 1, 24'sd7);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency();
      test_mixed();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
